// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: rv32i packet type, opcode constants and fetch FSM states
package fetch_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] next_pc;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } rv32i_data_t;

    typedef struct packed {
        logic        valid;
        rv32i_data_t data;
    } rv32i_packet_t;

    localparam logic [6:0] op_jal = 7'b1101111;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t HOLD  = 2'd1;
    localparam fetch_state_t KILL  = 2'd2;

endpackage

// File: rtl/fetch_stage_next_pc_predict.sv
// next_pc_predict: static next-pc guess, fall-through or JAL target
module next_pc_predict
    import fetch_stage_pkg::*;
#(
    parameter bit JAL_PREDICT = 1'b1
) (
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] next_pc
);

    logic [31:0] j_imm;

    always_comb begin
        j_imm   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        next_pc = (JAL_PREDICT && inst[6:0] == op_jal) ? pc + j_imm : pc + 32'd4;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives I-cache requests and the IF fields of the IF/ID packet
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0060,
    parameter bit          JAL_PREDICT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          imem_read,
    output logic [31:0]   imem_address,
    input  logic          imem_resp,
    input  logic [31:0]   imem_rdata,
    output rv32i_packet_t packet_out
);

    fetch_state_t state;
    logic [31:0]  pc, req_addr, hold_inst, hold_next, pred_next, target;

    next_pc_predict #(.JAL_PREDICT(JAL_PREDICT)) u_pred (
        .pc      (pc),
        .inst    (imem_rdata),
        .next_pc (pred_next)
    );

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= '0;
            hold_inst <= '0;
            hold_next <= '0;
        end else if (redirect_valid) begin
            // an unanswered request must be drained at its original address
            pc       <= target;
            req_addr <= (state == FETCH) ? pc : req_addr;
            state    <= (state != HOLD && !imem_resp) ? KILL : FETCH;
        end else if (state == FETCH && imem_resp && !stall) begin
            pc <= pred_next;
        end else if (state == FETCH && imem_resp) begin
            hold_inst <= imem_rdata;
            hold_next <= pred_next;
            state     <= HOLD;
        end else if (state == HOLD && !stall) begin
            pc    <= hold_next;
            state <= FETCH;
        end else if (state == KILL && imem_resp) begin
            state <= FETCH;
        end
    end

    always_comb begin
        imem_read                     = rst_n && state != HOLD;
        imem_address                  = (state == KILL) ? req_addr : pc;
        packet_out                    = '0;
        packet_out.valid              = rst_n && !redirect_valid &&
                                        (state == HOLD || (state == FETCH && imem_resp));
        packet_out.data.pc            = rst_n ? pc : '0;
        packet_out.data.instruction   = !rst_n ? '0 : (state == HOLD) ? hold_inst : imem_rdata;
        packet_out.data.next_pc       = !rst_n ? '0 : (state == HOLD) ? hold_next : pred_next;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage. Owns the PC, issues requests to the I-cache, and builds the IF-side fields of the rv32i packet (valid, pc, instruction, next_pc). Those fields drive the IF/ID pipeline buffer through its load_ifid path.
Handles I-cache latency, downstream stall, and redirects from EX on a misprediction. It uses static fall-through prediction with optional JAL target prediction.

Parameters:
RESET_PC, 32'h0000_0060, PC value loaded on reset.
JAL_PREDICT, 1, 1 = predict JAL target in IF; 0 = always predict pc+4.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
stall  in  1  IF/ID buffer will not accept this cycle (hazard unit / D-cache miss)
redirect_valid  in  1  EX found a wrong next_pc; flush and refetch
redirect_pc  in  32  correct target; bits [1:0] ignored and forced to 0
imem_read  out  1  I-cache read request
imem_address  out  32  I-cache address; word aligned
imem_resp  in  1  I-cache response, one-cycle pulse
imem_rdata  in  32  instruction word, valid when imem_resp=1
packet_out  out  rv32i_packet_t  valid, data.pc, data.instruction, data.next_pc driven; all other fields '0

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=FETCH, hold registers cleared.
  - Outputs while in reset: imem_read=0, packet_out='0.
- First cycle after reset: imem_read=1, imem_address=RESET_PC.
- next_pc function f(pc, inst):
  - If JAL_PREDICT=1 and inst[6:0]=7'b1101111: pc + sign-extended J-immediate.
  - Otherwise: pc+4.
  - 32-bit wrap-around, no overflow flag.
- packet_out is combinational; the IF/ID buffer performs the registering.
- States:
  - FETCH: request outstanding at pc.
  - HOLD: instruction captured and waiting for stall to drop.
  - KILL: a redirect arrived while a request was outstanding; the stale response must be discarded.
- FETCH:
  - imem_read=1, imem_address=pc.
  - No imem_resp: packet valid=0, stay in FETCH.
  - imem_resp and no redirect:
    - packet valid=1, pc=pc, instruction=imem_rdata, next_pc=f(pc, imem_rdata).
    - If stall=0: pc<=next_pc, stay in FETCH. This gives back-to-back fetch with the new address driven the next cycle.
    - If stall=1: capture inst and next_pc into hold registers, go to HOLD.
  - redirect_valid with imem_resp the same cycle: drop the response (valid=0), pc<=redirect_pc, stay in FETCH.
  - redirect_valid without imem_resp: latch the old address into req_addr, pc<=redirect_pc, go to KILL.
- HOLD:
  - imem_read=0; packet valid=1 with the held pc, instruction and next_pc.
  - stall=0: pc<=held next_pc, go to FETCH.
  - redirect_valid (highest priority, stall irrelevant): valid=0, pc<=redirect_pc, go to FETCH.
- KILL:
  - imem_read=1, imem_address=req_addr. The address stays stable until resp; the cache protocol requires this.
  - packet valid=0.
  - imem_resp: discard it, go to FETCH (pc already equals the target).
  - A further redirect_valid in KILL: overwrite pc, stay in KILL.
- Global rules:
  - redirect_valid always forces packet valid=0 in that cycle.
  - stall never changes pc, except via HOLD exit or a redirect.
  - imem_address never changes while imem_read=1 and no resp has arrived.
- Reset mid-operation: abandon any outstanding request; imem_read drops immediately (async). After reset, refetch from RESET_PC.

Decomposition:
- rv32i_packet (shared package): packet type, unchanged.
- rv32i_types (shared package): opcode constant op_jal and fetch_state_t enum {FETCH, HOLD, KILL}.
- Sub-module next_pc_predict: combinational f(pc, inst) with JAL_PREDICT parameter, reusable by a future BTB.

Test Plan:
- Reset release, 1-cycle cache, stall=0: addresses 0x60, 0x64, 0x68 on consecutive cycles; packets valid with next_pc=pc+4.
- JAL at 0x60 with imem_rdata=32'h0100006F (jal x0,+16): packet next_pc=0x70; next imem_address=0x70. With JAL_PREDICT=0: next_pc=0x64.
- Resp at 0x64 while stall=1 for 3 cycles: HOLD, imem_read=0, packet held valid (pc=0x64) for all 3 cycles. Stall drops, then imem_address=0x68 the next cycle.
- 4-cycle cache latency, redirect_valid with redirect_pc=0x203 in cycle 2:
  - imem_address stays at the old value until resp.
  - The response is dropped and valid=0 throughout.
  - The next request is 0x200.
- redirect in HOLD and, separately, redirect coincident with imem_resp: valid=0 that cycle and the next fetch is from redirect_pc.
- Assert rst_n low while in KILL: imem_read and packet_out.valid go 0 without waiting for a clock edge; after release the fetch address is 0x60.
